// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch stage.
// Reset address default, instruction width, buffer entry type.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer for the fetch stage.
// Synchronous FIFO with flush, occupancy count and register-fed head.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output logic                     valid,
  output fetch_entry_t             data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  wptr;

  assign valid = (count != '0);
  assign data  = mem[rptr];

  // Storage array; a flush makes any write in the same cycle irrelevant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage.
// Issues in-order word fetches, buffers returns, handles redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fence,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_idle
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Stale responses can pile up over back-to-back redirects.
  localparam int DW = CW + 2;
  localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [DW-1:0] drop;

  logic          req_hs;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          pop;
  logic [CW:0]   used;
  logic [31:0]   target;
  fetch_entry_t  head;
  logic          unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];

  assign target   = {redirect_pc[31:2], 2'b00};
  assign used     = {1'b0, outstanding} + {1'b0, count};
  assign req_hs   = imem_req_valid & imem_req_ready;
  assign rsp_keep = imem_rsp_valid & (drop == '0);
  assign rsp_drop = imem_rsp_valid & (drop != '0);
  assign pop      = instr_valid & instr_ready;

  assign imem_req_valid = reset & ~fence & ~redirect_valid & (used < CAP);
  assign imem_addr      = fetch_pc;
  assign instr          = head.word;
  assign pc             = head_pc;
  assign fetch_idle     = (outstanding == '0) & (drop == '0) & (count == '0);

  // Fetch and head PCs; a redirect restarts both at the target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      head_pc  <= target;
    end else begin
      if (req_hs) fetch_pc <= fetch_pc + 32'd4;
      if (pop)    head_pc  <= head_pc + 32'd4;
    end
  end

  // In-flight and to-be-discarded response counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      outstanding <= '0;
      drop        <= drop + DW'(outstanding) + DW'(req_hs)
                   - DW'(imem_rsp_valid);
    end else begin
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_keep);
      drop        <= drop - DW'(rsp_drop);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ('{word: imem_rsp_data}),
    .pop       (pop),
    .valid     (instr_valid),
    .data      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random memory and decode against a
// queue-based model of requests, responses and delivered PCs.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fence;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fetch_idle;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fence          (fence),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc             (pc),
    .fetch_idle     (fetch_idle)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] exp_fetch;
  logic [31:0] exp_head;
  int          cyc;
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  int          n_chk;
  int          n_err;

  logic        rdr;
  logic [31:0] rdr_pc;
  logic        fen;
  logic        rdy;
  logic        irdy;

  bit          ev_hs;
  logic [31:0] ev_hs_addr;
  bit          ev_pop;
  logic [31:0] ev_pop_pc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int count_live();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].live) n++;
    return n;
  endfunction

  // One clock cycle: drive, check outputs, advance the model.
  task automatic step();
    bit    rv;
    bit    hs;
    bit    pp;
    int    live;
    int    lat;
    mreq_t m;
    redirect_valid = rdr;
    redirect_pc    = rdr_pc;
    fence          = fen;
    imem_req_ready = rdy;
    instr_ready    = irdy;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? word(mem_q[0].addr) : $urandom;
    #1;
    live = count_live();
    check("req_valid", 32'(imem_req_valid),
          32'(!fen && !rdr && (live + buf_q.size() < DEPTH)));
    if (imem_req_valid) check("req_addr", imem_addr, exp_fetch);
    check("instr_valid", 32'(instr_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) check("instr", instr, buf_q[0]);
    check("pc", pc, exp_head);
    check("idle", 32'(fetch_idle),
          32'(mem_q.size() == 0 && buf_q.size() == 0));
    hs = imem_req_valid && rdy;
    pp = instr_valid && irdy;
    ev_hs      = hs;
    ev_hs_addr = imem_addr;
    ev_pop     = pp && !rdr;
    ev_pop_pc  = pc;
    if (pp && buf_q.size() != 0) begin
      void'(buf_q.pop_front());
      exp_head += 32'd4;
    end
    if (rv) begin
      m = mem_q.pop_front();
      if (m.live) buf_q.push_back(word(m.addr));
    end
    if (hs) begin
      lat    = $urandom_range(lat_hi, lat_lo);
      m.addr = exp_fetch;
      m.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      m.live = 1'b1;
      last_due = m.due;
      mem_q.push_back(m);
      exp_fetch += 32'd4;
    end
    if (rdr) begin
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
      buf_q.delete();
      exp_fetch = {rdr_pc[31:2], 2'b00};
      exp_head  = {rdr_pc[31:2], 2'b00};
    end
    check("buf_bound", 32'(buf_q.size() <= DEPTH), 32'd1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(logic [31:0] a);
    rdr    = 1'b1;
    rdr_pc = a;
    step();
    rdr    = 1'b0;
  endtask

  task automatic reset_vals(string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_addr"}, imem_addr, RPC);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_pc"}, pc, RPC);
    check({tag, "_idle"}, 32'(fetch_idle), 32'd1);
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_hs;
    int first_v;
    int npop;
    int nhs;
    int got;
    logic [31:0] pcs [2];
    logic [31:0] addrs [3];
    logic [31:0] fa;

    n_chk = 0; n_err = 0; cyc = 0; last_due = -1;
    lat_lo = 1; lat_hi = 1;
    rdr = 0; rdr_pc = 0; fen = 0; rdy = 1; irdy = 1;
    reset = 1'b0;
    redirect_valid = 0; redirect_pc = 0; fence = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    instr_ready = 0;
    exp_fetch = RPC; exp_head = RPC;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    reset = 1'b1;

    // Sequential start: first instruction two cycles after handshake.
    first_hs = -1; first_v = -1; npop = 0;
    for (int i = 0; i < 20; i++) begin
      got = cyc;
      step();
      if (ev_hs && first_hs < 0) first_hs = got;
      if (ev_pop) begin
        if (first_v < 0) first_v = got;
        if (npop < 2) pcs[npop] = ev_pop_pc;
        npop++;
      end
    end
    check("first_lat", 32'(first_v - first_hs), 32'd2);
    check("first_hs_cyc", 32'(first_hs), 32'd0);
    check("first_pc0", pcs[0], 32'h0);
    check("first_pc1", pcs[1], 32'h4);

    // Decode stalled: the buffer caps requests at DEPTH.
    irdy = 0;
    redirect_to(32'h0000_0200);
    nhs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ev_hs) nhs++;
    end
    check("stall_reqs", 32'(nhs), 32'(DEPTH));
    irdy = 1;
    step();
    irdy = 0;
    nhs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ev_hs) nhs++;
    end
    check("stall_refill", 32'(nhs), 32'd1);

    // Redirect with two requests in flight.
    irdy = 1; lat_lo = 4; lat_hi = 4;
    got = 0;
    for (int i = 0; i < 40 && count_live() != 2; i++) step();
    check("rdr_setup", 32'(count_live()), 32'd2);
    redirect_to(32'h0000_0103);
    fa = 32'hDEAD_BEEF;
    pcs[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ev_hs && fa == 32'hDEAD_BEEF) fa = ev_hs_addr;
      if (ev_pop && pcs[0] == 32'hDEAD_BEEF) pcs[0] = ev_pop_pc;
    end
    check("rdr_addr", fa, 32'h0000_0100);
    check("rdr_pc", pcs[0], 32'h0000_0100);

    // Fence with one request in flight.
    lat_lo = 3; lat_hi = 3;
    redirect_to(32'h0000_0300);
    step();
    check("fence_setup", 32'(count_live()), 32'd1);
    fen = 1;
    fa = exp_fetch;
    nhs = 0; npop = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ev_hs) nhs++;
      if (ev_pop) npop++;
    end
    fen = 0;
    check("fence_reqs", 32'(nhs), 32'd0);
    check("fence_pops", 32'(npop), 32'd1);
    got = 0;
    for (int i = 0; i < 10 && !ev_hs; i++) step();
    check("fence_resume", ev_hs ? ev_hs_addr : 32'hDEAD_BEEF,
          32'h0000_0304);

    // Address wrap at the top of the space.
    lat_lo = 1; lat_hi = 1;
    redirect_to(32'hFFFF_FFF8);
    nhs = 0;
    for (int i = 0; i < 20 && nhs < 3; i++) begin
      step();
      if (ev_hs) begin
        addrs[nhs] = ev_hs_addr;
        nhs++;
      end
    end
    check("wrap_n", 32'(nhs), 32'd3);
    check("wrap_a0", addrs[0], 32'hFFFF_FFF8);
    check("wrap_a1", addrs[1], 32'hFFFF_FFFC);
    check("wrap_a2", addrs[2], 32'h0000_0000);

    // Random traffic.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      rdr    = ($urandom_range(99, 0) < 3);
      rdr_pc = $urandom;
      fen    = ($urandom_range(99, 0) < 8);
      rdy    = ($urandom_range(3, 0) != 0);
      irdy   = ($urandom_range(3, 0) != 0);
      step();
    end
    rdr = 0; fen = 0; rdy = 1; irdy = 0;
    lat_lo = 3; lat_hi = 3;

    // Reset mid-operation with a buffered and an in-flight word.
    redirect_to(32'h0000_0400);
    for (int i = 0; i < 40; i++) begin
      if (buf_q.size() >= 1 && count_live() == 1) break;
      step();
    end
    check("mid_setup", 32'(buf_q.size() >= 1 && count_live() == 1), 32'd1);
    check("mid_valid_before", 32'(instr_valid), 32'd1);
    reset = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    reset_vals("mid");
    mem_q.delete();
    buf_q.delete();
    exp_fetch = RPC;
    exp_head  = RPC;
    @(posedge clk);
    #1;
    last_due = cyc;
    reset = 1'b1;
    irdy = 1; lat_lo = 1; lat_hi = 2;
    fa = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ev_hs && fa == 32'hDEAD_BEEF) fa = ev_hs_addr;
    end
    check("mid_restart", fa, RPC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32 core. It owns the architectural fetch PC, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs for decode. It accepts redirects from the next-PC/branch control logic and feeds that logic the PC of the instruction being handed to decode. Younger work is flushed and stale memory responses are discarded on redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
- DEPTH, 2, instruction buffer entries; power of two, 2..8; also the cap on in-flight requests plus buffered entries

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- redirect_valid  in  1  one-cycle pulse: taken branch/jump, flush and restart
- redirect_pc  in  32  restart address; bits [1:0] ignored (treated as 0)
- fence  in  1  while high, no new memory requests issue; in-flight requests complete
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  word address of request, bits [1:0] = 0
- imem_rsp_valid  in  1  response valid; in-order, never back-pressured, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- pc  out  32  address of head instruction (to next-PC control)
- fetch_idle  out  1  no requests in flight and buffer empty

## Operation
- State: fetch_pc (next request address), head_pc, buffer count, outstanding count, drop count.
- Issue condition: not in reset, not fence, no redirect this cycle, outstanding + count < DEPTH. imem_req_valid = issue condition; imem_addr = fetch_pc.
- Request handshake (valid & ready): fetch_pc += 4, outstanding += 1. Addition is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Response with drop = 0: push imem_rsp_data into buffer, outstanding -= 1. With drop > 0: discard, drop -= 1.
- Decode handshake (instr_valid & instr_ready): pop head, head_pc += 4.
- pc = head_pc at all times, including when the buffer is empty (points at the next instruction to arrive).
- Redirect: the following cycle shows fetch_pc = head_pc = {redirect_pc[31:2],2'b00}, buffer empty, drop = drop + outstanding (including a request accepted in the redirect cycle, excluding a response arriving in the redirect cycle), outstanding = 0. Any pop or push in the redirect cycle is overridden by the flush.
- imem_req_valid may drop before ready only on redirect or fence assertion; otherwise it holds with a stable addr.
- Simultaneous push and pop with a full buffer is legal; the credit rule prevents overflow. Overflow or an unexpected response (outstanding + drop = 0) is a bench assertion failure.
- fetch_idle = (outstanding = 0) & (drop = 0) & (count = 0).

## Timing
- Reset values: imem_req_valid 0 while reset low, imem_addr RESET_PC, instr_valid 0, instr 0, pc RESET_PC, fetch_idle 1, all counters 0.
- First request occurs in the first cycle after reset deasserts.
- Request accepted at N, response at N+1 gives instr_valid at N+2 (the buffer output is registered). There is no combinational path from imem_rsp_* to instr_*.
- Redirect at cycle R gives a request to the new target at R+1. The first new instruction is valid at R+3 at the earliest.
- There is no combinational path from instr_ready to imem_req_valid. Credit uses registered counts.
- Reset asserted mid-operation clears all state asynchronously. Responses arriving after reset release are not expected; the memory shares the same reset.

## Structure
- Shared core package: RESET_PC default constant, INSTR_W = 32, typedef fetch_entry_t (instruction word).
- One sub-module, fetch_fifo: synchronous FIFO parameterised by DEPTH, with a flush input, count output, and registered data output.
- Counters are sized $clog2(DEPTH)+1 bits.

## Test plan
- Reset release with RESET_PC=0, memory ready, and 1-cycle latency → addresses 0,4,8… issued. The first instr_valid occurs 2 cycles after the first handshake, with pc=0, then 4.
- instr_ready held low with DEPTH=2 → exactly 2 requests issued, then imem_req_valid stays 0 until one pop.
- Redirect to 32'h0000_0103 with 2 in flight → both responses dropped. The next request goes to 0x100, and the first delivered instruction has pc=0x100.
- fence high for 5 cycles with 1 in flight → no new requests, the in-flight instruction is delivered, and fetch resumes at the next sequential address when fence drops.
- fetch_pc 32'hFFFF_FFF8 → requests go to FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Reset asserted while instr_valid=1 and 1 request is in flight → outputs return to reset values immediately, and fetch restarts at RESET_PC.
